kernel_launch_seq: RTL and testbench
====================================

KERNEL_LAUNCH_SEQ -- requirements
Module: kernel_launch_seq

Interface
REQ-001 Parameter MAX_ARGS, default 16: argument table depth in 64-bit words; index width IDX_W = $clog2(MAX_ARGS).
REQ-002 Parameter TIMEOUT_CYCLES, default 1000000: cycles the block waits for the kernel interrupt; used only under KLAUNCH_TIMEOUT_EN.
REQ-003 clock  in  1  sole clock; all logic is rising-edge.
REQ-004 resetn  in  1  asynchronous active-low reset.
REQ-005 launch  in  1  one-cycle start request.
REQ-006 num_args  in  IDX_W+1  number of argument words to write; sampled when launch is accepted.
REQ-007 arg_rd_idx  out  IDX_W  argument table read index.
REQ-008 arg_rd_addr / arg_rd_data / arg_rd_be  in  4 / 64 / 8  table entry (CRA address, data, byteenable); valid one cycle after arg_rd_idx is presented.
REQ-009 cra_address / cra_writedata / cra_byteenable  out  4 / 64 / 8  Avalon-MM CRA master command.
REQ-010 cra_write / cra_read  out  1 / 1  CRA command strobes.
REQ-011 cra_waitrequest  in  1  CRA slave stall; tie to 0 when the slave has none.
REQ-012 cra_readdata / cra_readdatavalid  in  64 / 1  CRA read response.
REQ-013 kernel_irq  in  1  kernel completion interrupt, level.
REQ-014 busy / done / error  out  1 / 1 / 1  launch in progress / one-cycle completion pulse / timeout flag.
REQ-015 status  out  32  kernel status word captured at completion.

Function
REQ-016 FSM states SHALL be IDLE, FETCH, WRITE, GO, WAIT_IRQ, STAT_RD, STAT_WAIT, FINISH.
REQ-017 IDLE: launch=1 with num_args>0 -> FETCH with idx=0; launch=1 with num_args=0 -> GO; busy=0 only in IDLE.
REQ-018 launch while busy=1 SHALL be ignored; num_args > MAX_ARGS SHALL be clamped to MAX_ARGS.
REQ-019 FETCH: drive arg_rd_idx=idx for one cycle -> WRITE.
REQ-020 WRITE: cra_write=1 with the table entry, held stable until a cycle with cra_waitrequest=0; then idx+1, and -> FETCH if idx+1 < count, else -> GO.
REQ-021 With waitrequest low, each argument SHALL take exactly 2 cycles.
REQ-022 GO: cra_write=1, cra_address=0, cra_writedata=64'h1, cra_byteenable=8'h0F, held until waitrequest=0 -> WAIT_IRQ.
REQ-023 WAIT_IRQ: kernel_irq=1 -> STAT_RD; kernel_irq already high on entry SHALL be accepted immediately.
REQ-024 STAT_RD: cra_read=1, cra_address=0, cra_byteenable=8'h0F, held until waitrequest=0 -> STAT_WAIT.
REQ-025 STAT_WAIT: on cra_readdatavalid=1 capture status=cra_readdata[31:0] -> FINISH.
REQ-026 FINISH: done=1 for exactly one cycle -> IDLE; status and error SHALL hold until the next accepted launch, which clears both.
REQ-027 cra_write and cra_read SHALL never be asserted in the same cycle; unused command fields SHALL be 0.

Reset
REQ-028 resetn low SHALL force IDLE, idx=0, busy=0, done=0, error=0, status=0, cra_write=0, cra_read=0, all command fields 0, timeout counter 0.
REQ-029 Reset asserted mid-operation SHALL abort immediately, with no further CRA strobes after release until a new launch.

Configuration
REQ-030 With KLAUNCH_TIMEOUT_EN defined: a counter SHALL run in WAIT_IRQ; after TIMEOUT_CYCLES cycles without kernel_irq, error=1, status unchanged, -> FINISH (done pulses).
REQ-031 Without KLAUNCH_TIMEOUT_EN: no counter exists, WAIT_IRQ waits indefinitely, and error SHALL be tied 0.

Structure
REQ-032 Shared package klaunch_pkg SHALL hold the state enum, CRA_START_ADDR=4'h0, CRA_START_DATA=64'h1, and CRA_STATUS_ADDR=4'h0.
REQ-033 The block SHALL be a single module with no sub-module; the argument table is external.

Verification
REQ-034 num_args=3, table {(5,64'h1_0000_0000,F0),(6,64'h1,0F),(D,64'h40_0000,0F)}, waitrequest=0 -> three writes in order every 2 cycles, then a start write (0,1,0F).
REQ-035 waitrequest held high 4 cycles on the 2nd argument write -> command stable all 4 cycles, exactly one write accepted, order preserved.
REQ-036 num_args=0 -> start write on the cycle after launch; kernel_irq returned with readdata=32'h0000_0002 -> status=2, done pulses once, busy falls.
REQ-037 launch pulsed during WAIT_IRQ -> ignored, with no extra CRA traffic; resetn pulsed in WRITE -> all outputs 0, no strobes until the next launch.
REQ-038 KLAUNCH_TIMEOUT_EN, TIMEOUT_CYCLES=100, kernel_irq never asserted -> error=1 and done pulse 100 cycles after WAIT_IRQ entry; next launch clears error.

Source files
------------

// File: rtl/kernel_launch_seq_pkg.sv
// klaunch_pkg: state encoding and fixed CRA command constants shared by kernel_launch_seq
package klaunch_pkg;
    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        WRITE,
        GO,
        WAIT_IRQ,
        STAT_RD,
        STAT_WAIT,
        FINISH
    } klaunch_state_e;
    localparam logic [3:0]  CRA_START_ADDR  = 4'h0;
    localparam logic [63:0] CRA_START_DATA  = 64'h1;
    localparam logic [3:0]  CRA_STATUS_ADDR = 4'h0;
    localparam logic [7:0]  CRA_CTRL_BE     = 8'h0F;
endpackage

// File: rtl/kernel_launch_seq_if.sv
// kernel_launch_seq_if: Avalon-MM CRA master command/response bundle
interface kernel_launch_seq_if;
    logic [3:0]  cra_address;
    logic [63:0] cra_writedata;
    logic [7:0]  cra_byteenable;
    logic        cra_write;
    logic        cra_read;
    logic        cra_waitrequest;
    logic [63:0] cra_readdata;
    logic        cra_readdatavalid;
    modport master (
        output cra_address, cra_writedata, cra_byteenable, cra_write, cra_read,
        input  cra_waitrequest, cra_readdata, cra_readdatavalid
    );
    modport slave (
        input  cra_address, cra_writedata, cra_byteenable, cra_write, cra_read,
        output cra_waitrequest, cra_readdata, cra_readdatavalid
    );
endinterface

// File: rtl/kernel_launch_seq.sv
// kernel_launch_seq: writes kernel arguments over CRA, starts the kernel, waits for its
// interrupt and reads back the status word. Optional interrupt timeout: KLAUNCH_TIMEOUT_EN.
module kernel_launch_seq
    import klaunch_pkg::*;
#(
    parameter int MAX_ARGS       = 16,
    parameter int TIMEOUT_CYCLES = 1000000,
    localparam int IDX_W         = $clog2(MAX_ARGS)
) (
    input  logic               clock,
    input  logic               resetn,
    input  logic               launch,
    input  logic [IDX_W:0]     num_args,
    output logic [IDX_W-1:0]   arg_rd_idx,
    input  logic [3:0]         arg_rd_addr,
    input  logic [63:0]        arg_rd_data,
    input  logic [7:0]         arg_rd_be,
    kernel_launch_seq_if.master cra,
    input  logic               kernel_irq,
    output logic               busy,
    output logic               done,
    output logic               error,
    output logic [31:0]        status
);
    localparam logic [IDX_W:0] MAX_CNT = (IDX_W + 1)'(MAX_ARGS);

    klaunch_state_e r_state, w_next;
    logic [IDX_W:0] r_idx, r_cnt;
    logic [31:0]    r_status;
    logic [IDX_W:0] w_idx_inc, w_cnt_in;
    logic           w_acc, w_start, w_timeout, w_wr_arg, w_go, w_rd, w_unused;

    assign w_acc     = !cra.cra_waitrequest;
    assign w_start   = (r_state == IDLE) && launch;
    assign w_idx_inc = r_idx + 1'b1;
    assign w_cnt_in  = (num_args > MAX_CNT) ? MAX_CNT : num_args;
    assign w_unused  = ^{cra.cra_readdata[63:32], 32'(TIMEOUT_CYCLES)};

`ifdef KLAUNCH_TIMEOUT_EN
    localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [TMO_W-1:0] r_tmo;
    logic             r_error;
    assign w_timeout = (r_tmo == TMO_W'(TIMEOUT_CYCLES - 1));
    assign error     = r_error;
    // count idle cycles in WAIT_IRQ; flag error when the budget runs out, clear on a new launch
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_tmo   <= '0;
            r_error <= 1'b0;
        end else begin
            r_tmo <= (r_state == WAIT_IRQ && !kernel_irq) ? r_tmo + 1'b1 : '0;
            if (w_start)
                r_error <= 1'b0;
            else if (r_state == WAIT_IRQ && !kernel_irq && w_timeout)
                r_error <= 1'b1;
        end
    end
`else
    assign w_timeout = 1'b0;
    assign error     = 1'b0;
`endif

    // next-state: every CRA command state holds until the slave drops waitrequest
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:      if (launch) w_next = (w_cnt_in == '0) ? GO : FETCH;
            FETCH:     w_next = WRITE;
            WRITE:     if (w_acc) w_next = (w_idx_inc < r_cnt) ? FETCH : GO;
            GO:        if (w_acc) w_next = WAIT_IRQ;
            WAIT_IRQ:  w_next = kernel_irq ? STAT_RD : (w_timeout ? FINISH : WAIT_IRQ);
            STAT_RD:   if (w_acc) w_next = STAT_WAIT;
            STAT_WAIT: if (cra.cra_readdatavalid) w_next = FINISH;
            FINISH:    w_next = IDLE;
            default:   w_next = IDLE;
        endcase
    end

    // state, argument index/count and status capture
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_state  <= IDLE;
            r_idx    <= '0;
            r_cnt    <= '0;
            r_status <= '0;
        end else begin
            r_state <= w_next;
            if (w_start) begin
                r_idx    <= '0;
                r_cnt    <= w_cnt_in;
                r_status <= '0;
            end else if (r_state == WRITE && w_acc) begin
                r_idx <= w_idx_inc;
            end
            if (r_state == STAT_WAIT && cra.cra_readdatavalid)
                r_status <= cra.cra_readdata[31:0];
        end
    end

    // the table index stays on idx through WRITE so the table keeps presenting the entry
    // while the slave stalls; command fields are zero whenever no strobe is active
    assign w_wr_arg           = (r_state == WRITE);
    assign w_go               = (r_state == GO);
    assign w_rd               = (r_state == STAT_RD);
    assign arg_rd_idx         = r_idx[IDX_W-1:0];
    assign cra.cra_write      = w_wr_arg || w_go;
    assign cra.cra_read       = w_rd;
    assign cra.cra_address    = w_wr_arg ? arg_rd_addr : (w_go ? CRA_START_ADDR : (w_rd ? CRA_STATUS_ADDR : 4'h0));
    assign cra.cra_writedata  = w_wr_arg ? arg_rd_data : (w_go ? CRA_START_DATA : 64'h0);
    assign cra.cra_byteenable = w_wr_arg ? arg_rd_be : ((w_go || w_rd) ? CRA_CTRL_BE : 8'h0);
    assign busy               = (r_state != IDLE);
    assign done               = (r_state == FINISH);
    assign status             = r_status;
endmodule

// File: tb/tb_kernel_launch_seq.sv
// tb_kernel_launch_seq: randomized launches checked against a transaction-level model of
// the expected CRA write list, timing, status and flags. Define KLAUNCH_TIMEOUT_EN for the timeout case.
module tb_kernel_launch_seq;
    localparam int MAX_ARGS = 16;
    localparam int TMO      = 100;

    typedef struct {
        logic [3:0]  a;
        logic [63:0] d;
        logic [7:0]  b;
        int          c;
    } wr_t;

    logic        clock = 0, resetn = 1, launch = 0, kernel_irq = 0, wreq = 0;
    logic [4:0]  num_args = 0;
    logic [3:0]  arg_rd_idx, arg_rd_addr;
    logic [63:0] arg_rd_data;
    logic [7:0]  arg_rd_be;
    logic        busy, done, error;
    logic [31:0] status;
    logic [3:0]  t_addr [MAX_ARGS];
    logic [63:0] t_data [MAX_ARGS];
    logic [7:0]  t_be   [MAX_ARGS];

    int n_cmp = 0, n_bad = 0, cyc = 0, wr_mode = 0, st_n = 0;
    int n_rd = 0, n_done = 0, rd_c = 0, done_c = 0;
    wr_t got[$];
    logic        stall_p = 0;
    logic [3:0]  a_p;
    logic [7:0]  b_p;
    logic [63:0] d_p;

    kernel_launch_seq_if cra();

    kernel_launch_seq #(.MAX_ARGS(MAX_ARGS), .TIMEOUT_CYCLES(TMO)) dut (
        .clock(clock), .resetn(resetn), .launch(launch), .num_args(num_args),
        .arg_rd_idx(arg_rd_idx), .arg_rd_addr(arg_rd_addr), .arg_rd_data(arg_rd_data),
        .arg_rd_be(arg_rd_be), .cra(cra), .kernel_irq(kernel_irq),
        .busy(busy), .done(done), .error(error), .status(status)
    );

    assign cra.cra_waitrequest = wreq;

    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    // external argument table: registered read, entry valid the cycle after the index
    always @(posedge clock) begin
        arg_rd_addr <= t_addr[arg_rd_idx];
        arg_rd_data <= t_data[arg_rd_idx];
        arg_rd_be   <= t_be[arg_rd_idx];
    end

    // slave stall pattern: none, random, or 4 cycles on the second argument write
    always @(posedge clock) begin
        #1;
        if (wr_mode == 1) begin
            wreq = ($urandom_range(0, 2) == 0);
        end else if (wr_mode == 2 && cra.cra_write && arg_rd_idx == 4'd1 && st_n < 4) begin
            wreq = 1;
            st_n++;
        end else begin
            wreq = 0;
            if (wr_mode != 2) st_n = 0;
        end
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    // bus monitor
    always @(negedge clock) begin
        check("rw_excl", 64'(cra.cra_write & cra.cra_read), 64'h0);
        if (!cra.cra_write && !cra.cra_read)
            check("idle_cmd", cra.cra_writedata | 64'(cra.cra_byteenable) | 64'(cra.cra_address), 64'h0);
        if (stall_p) begin
            check("stall_cmd", {51'b0, cra.cra_write, cra.cra_address, cra.cra_byteenable}, {51'b0, 1'b1, a_p, b_p});
            check("stall_data", cra.cra_writedata, d_p);
        end
        if (cra.cra_write && !wreq)
            got.push_back('{a: cra.cra_address, d: cra.cra_writedata, b: cra.cra_byteenable, c: cyc});
        if (cra.cra_read && !wreq) begin
            n_rd++;
            rd_c = cyc;
            check("rd_cmd", {52'b0, cra.cra_address, cra.cra_byteenable}, {52'b0, 4'h0, 8'h0F});
        end
        if (done) begin
            n_done++;
            done_c = cyc;
        end
        stall_p = cra.cra_write && wreq;
        a_p = cra.cra_address;
        b_p = cra.cra_byteenable;
        d_p = cra.cra_writedata;
    end

    task automatic pos();
        @(posedge clock);
        #1;
    endtask

    task automatic neg();
        @(negedge clock);
        #1;
    endtask

    // one launch; expected writes are the first min(n,MAX_ARGS) table entries then the start
    // word; with no stalls write k lands 2k+2 cycles after launch and the start at 2n+1
    task automatic do_launch(input int n, input bit rnd, input bit poke, input bit early,
                             input bit tmo, input logic [63:0] rdata);
        int nc, lc, t, g, r, d0, r0;
        bit timed;
        nc = (n > MAX_ARGS) ? MAX_ARGS : n;
        timed = (wr_mode == 0);
        if (rnd)
            for (int i = 0; i < MAX_ARGS; i++) begin
                t_addr[i] = 4'($urandom);
                t_data[i] = {$urandom, $urandom};
                t_be[i]   = 8'($urandom);
            end
        got.delete();
        d0 = n_done;
        r0 = n_rd;
        pos();
        kernel_irq = early;
        launch = 1;
        num_args = 5'(n);
        neg();
        lc = cyc;
        pos();
        launch = 0;
        neg();
        check("launch_busy", 64'(busy), 64'h1);
        check("launch_clr_err", 64'(error), 64'h0);
        check("launch_clr_status", 64'(status), 64'h0);
        t = 0;
        while (got.size() < nc + 1 && t < 400) begin
            neg();
            t++;
        end
        check("wr_count", 64'(got.size()), 64'(nc + 1));
        for (int k = 0; k < got.size() && k <= nc; k++) begin
            check("wr_addr_be", {52'b0, got[k].a, got[k].b},
                  (k < nc) ? {52'b0, t_addr[k], t_be[k]} : {52'b0, 4'h0, 8'h0F});
            check("wr_data", got[k].d, (k < nc) ? t_data[k] : 64'h1);
            if (timed) check("wr_cycle", 64'(got[k].c - lc), (k < nc) ? 64'(2 + 2 * k) : 64'(2 * nc + 1));
        end
        g = (got.size() > nc) ? got[nc].c : cyc;
        if (poke) begin
            pos();
            launch = 1;
            num_args = 5'($urandom_range(1, 16));
            pos();
            launch = 0;
            repeat (3) neg();
            check("poke_no_wr", 64'(got.size()), 64'(nc + 1));
            check("poke_no_rd", 64'(n_rd), 64'(r0));
            check("poke_busy", 64'(busy), 64'h1);
        end
        if (tmo) begin
            t = 0;
            while (n_done == d0 && t < 400) begin
                neg();
                t++;
            end
            check("tmo_done_cycle", 64'(done_c - g), 64'(1 + TMO));
            check("tmo_error", 64'(error), 64'h1);
            check("tmo_status", 64'(status), 64'h0);
        end else begin
            if (!early) begin
                repeat ($urandom_range(0, 5)) pos();
                kernel_irq = 1;
            end
            t = 0;
            while (n_rd == r0 && t < 200) begin
                neg();
                t++;
            end
            check("rd_count", 64'(n_rd), 64'(r0 + 1));
            if (timed && early) check("rd_cycle", 64'(rd_c - g), 64'h2);
            pos();
            repeat ($urandom_range(0, 3)) pos();
            cra.cra_readdata = rdata;
            cra.cra_readdatavalid = 1;
            r = cyc;
            pos();
            cra.cra_readdatavalid = 0;
            cra.cra_readdata = 64'h0;
            kernel_irq = 0;
            t = 0;
            while (n_done == d0 && t < 50) begin
                neg();
                t++;
            end
            check("done_cycle", 64'(done_c - r), 64'h1);
            check("status", 64'(status), 64'(rdata[31:0]));
            check("error_low", 64'(error), 64'h0);
        end
        neg();
        check("busy_fall", 64'(busy), 64'h0);
        check("done_once", 64'(n_done - d0), 64'h1);
    endtask

    initial begin
        int t, r0;
        bit early;
        cra.cra_readdata = 64'h0;
        cra.cra_readdatavalid = 0;
        for (int i = 0; i < MAX_ARGS; i++) begin
            t_addr[i] = 0;
            t_data[i] = 0;
            t_be[i] = 0;
        end
        resetn = 0;
        repeat (3) neg();
        check("rst_busy", 64'(busy), 64'h0);
        check("rst_done", 64'(done), 64'h0);
        check("rst_error", 64'(error), 64'h0);
        check("rst_status", 64'(status), 64'h0);
        check("rst_strobes", {62'b0, cra.cra_write, cra.cra_read}, 64'h0);
        check("rst_idx", 64'(arg_rd_idx), 64'h0);
        pos();
        resetn = 1;
        neg();
        check("post_rst_idle", 64'(busy), 64'h0);

        t_addr[0] = 4'h5; t_data[0] = 64'h1_0000_0000; t_be[0] = 8'hF0;
        t_addr[1] = 4'h6; t_data[1] = 64'h1;           t_be[1] = 8'h0F;
        t_addr[2] = 4'hD; t_data[2] = 64'h40_0000;     t_be[2] = 8'h0F;
        wr_mode = 0;
        do_launch(3, 0, 0, 0, 0, {$urandom, $urandom});

        wr_mode = 2;
        do_launch(3, 1, 0, 0, 0, {$urandom, $urandom});
        check("stall_len", 64'(st_n), 64'h4);

        wr_mode = 0;
        do_launch(0, 1, 0, 0, 0, 64'h0000_0000_0000_0002);
        do_launch(2, 1, 1, 0, 0, {$urandom, $urandom});
        do_launch(4, 1, 0, 1, 0, {$urandom, $urandom});
        do_launch(16, 1, 0, 0, 0, {$urandom, $urandom});
        do_launch(20, 1, 0, 0, 0, {$urandom, $urandom});
        do_launch(31, 1, 0, 1, 0, {$urandom, $urandom});

        for (int i = 0; i < 12; i++) begin
            wr_mode = $urandom_range(0, 1);
            early = 1'($urandom_range(0, 1));
            do_launch($urandom_range(0, 20), 1, !early && ($urandom_range(0, 1) == 1), early, 0,
                      {$urandom, $urandom});
        end

        wr_mode = 0;
        got.delete();
        r0 = n_rd;
        pos();
        launch = 1;
        num_args = 5'd10;
        pos();
        launch = 0;
        t = 0;
        while (got.size() < 2 && t < 50) begin
            neg();
            t++;
        end
        check("rst_mid_reached", 64'(got.size()), 64'h2);
        resetn = 0;
        #1;
        check("rst_mid_strobes", {62'b0, cra.cra_write, cra.cra_read}, 64'h0);
        check("rst_mid_cmd", cra.cra_writedata | 64'(cra.cra_byteenable) | 64'(cra.cra_address), 64'h0);
        check("rst_mid_flags", {61'b0, busy, done, error}, 64'h0);
        check("rst_mid_status", 64'(status), 64'h0);
        check("rst_mid_idx", 64'(arg_rd_idx), 64'h0);
        pos();
        pos();
        resetn = 1;
        repeat (10) neg();
        check("rst_no_wr", 64'(got.size()), 64'h2);
        check("rst_no_rd", 64'(n_rd), 64'(r0));
        check("rst_idle", 64'(busy), 64'h0);

`ifdef KLAUNCH_TIMEOUT_EN
        do_launch(2, 1, 0, 0, 1, 64'h0);
        do_launch(1, 1, 0, 0, 0, {$urandom, $urandom});
`endif
        do_launch(1, 1, 0, 0, 0, {$urandom, $urandom});

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
